// File: rtl/sound_mixer_sd.sv
// sound_mixer_sd: mixes two AY chips (six channels), beeper, tape-in and a covox sample into
// left/right 11-bit unsigned PCM, then drives two first-order sigma-delta 1-bit DAC pins.
//
// Ports:
//   clk28              system clock (28 MHz)
//   rst_n              asynchronous active-low reset
//   en, mute           output gate; PCM is forced to 0 unless en=1 and mute=0
//   mode               0=mono, 1=ABC, 2=ACB, 3=ABC
//   ay_a0..ay_c0       AY chip 0 channel levels
//   ay_a1..ay_c1       AY chip 1 channel levels
//   beeper, tape_in    1-bit sources, added as BEEP_LVL / TAPE_LVL
//   covox              unsigned 8-bit sample
//   left_pcm/right_pcm registered mix (2 edges after input)
//   dac_l/dac_r        sigma-delta bitstreams (first effect 3 edges after input)
module sound_mixer_sd #(
  parameter logic [7:0] BEEP_LVL = 8'd128,
  parameter logic [7:0] TAPE_LVL = 8'd32
) (
  input  logic        clk28,
  input  logic        rst_n,
  input  logic        en,
  input  logic        mute,
  input  logic [1:0]  mode,
  input  logic [7:0]  ay_a0,
  input  logic [7:0]  ay_b0,
  input  logic [7:0]  ay_c0,
  input  logic [7:0]  ay_a1,
  input  logic [7:0]  ay_b1,
  input  logic [7:0]  ay_c1,
  input  logic        beeper,
  input  logic        tape_in,
  input  logic [7:0]  covox,
  output logic [10:0] left_pcm,
  output logic [10:0] right_pcm,
  output logic        dac_l,
  output logic        dac_r
);

  // Per-chip panning: returns {cl, cr}, each 10 bits.
  function automatic logic [19:0] chip_mix(input logic [1:0] m, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] c);
    logic [9:0] sum3;
    logic [9:0] cl;
    logic [9:0] cr;
    sum3 = {2'b00, a} + {2'b00, b} + {2'b00, c};
    unique case (m)
      2'd0: begin
        cl = {1'b0, sum3[9:1]};
        cr = {1'b0, sum3[9:1]};
      end
      2'd2: begin
        cl = {2'b00, a} + {3'b000, c[7:1]};
        cr = {2'b00, b} + {3'b000, c[7:1]};
      end
      default: begin
        cl = {2'b00, a} + {3'b000, b[7:1]};
        cr = {2'b00, c} + {3'b000, b[7:1]};
      end
    endcase
    return {cl, cr};
  endfunction

  // Stage 1 state
  logic [9:0]  cl0_q, cr0_q, cl1_q, cr1_q, x_q;
  logic        gate_q;
  logic [19:0] mix0_d, mix1_d;
  logic [9:0]  x_d;

  // Stage 2 state
  logic [10:0] left_pcm_q, right_pcm_q;
  logic [10:0] left_pcm_d, right_pcm_d;

  // Stage 3 state
  logic [11:0] acc_l_q, acc_r_q;
  logic [11:0] acc_l_d, acc_r_d;
  logic        dac_l_q, dac_r_q;

  always_comb begin
    mix0_d = chip_mix(mode, ay_a0, ay_b0, ay_c0);
    mix1_d = chip_mix(mode, ay_a1, ay_b1, ay_c1);
    x_d    = {2'b00, covox}
           + (beeper  ? {2'b00, BEEP_LVL} : 10'd0)
           + (tape_in ? {2'b00, TAPE_LVL} : 10'd0);
  end

  always_comb begin
    left_pcm_d  = 11'd0;
    right_pcm_d = 11'd0;
    if (gate_q) begin
      left_pcm_d  = {1'b0, cl0_q} + {1'b0, cl1_q} + {1'b0, x_q};
      right_pcm_d = {1'b0, cr0_q} + {1'b0, cr1_q} + {1'b0, x_q};
    end
  end

  // Carry out of the 11-bit modulus is the DAC bit; it is cleared on the next add.
  always_comb begin
    acc_l_d = {1'b0, acc_l_q[10:0]} + {1'b0, left_pcm_q};
    acc_r_d = {1'b0, acc_r_q[10:0]} + {1'b0, right_pcm_q};
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      cl0_q       <= '0;
      cr0_q       <= '0;
      cl1_q       <= '0;
      cr1_q       <= '0;
      x_q         <= '0;
      gate_q      <= 1'b0;
      left_pcm_q  <= '0;
      right_pcm_q <= '0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      dac_l_q     <= 1'b0;
      dac_r_q     <= 1'b0;
    end else begin
      cl0_q       <= mix0_d[19:10];
      cr0_q       <= mix0_d[9:0];
      cl1_q       <= mix1_d[19:10];
      cr1_q       <= mix1_d[9:0];
      x_q         <= x_d;
      gate_q      <= en & ~mute;
      left_pcm_q  <= left_pcm_d;
      right_pcm_q <= right_pcm_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      dac_l_q     <= acc_l_d[11];
      dac_r_q     <= acc_r_d[11];
    end
  end

  assign left_pcm  = left_pcm_q;
  assign right_pcm = right_pcm_q;
  assign dac_l     = dac_l_q;
  assign dac_r     = dac_r_q;

endmodule
